dmem_ctrl: RTL and testbench

Parametrised single-port data memory with a request/ready handshake, per-byte write strobes, a registered read path, out-of-range detection, and a post-reset clear sequence. It replaces the fixed 128×32 combinational-read data memory in the single-cycle datapath and serves as the data-side slave for the multi-cycle and pipelined core variants. After reset it sweeps the array to zero, then accepts one access per cycle.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_ctrl.sv | 67 ++++++
 tb/tb_dmem_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the data memory controller.
package dmem_pkg;
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
  localparam int NBYTES = 32 / 8;
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port storage, byte-enable synchronous write, synchronous read, no reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [AW-1:0]       i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < DATA_W / 8; b++)
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) r_q <= r_mem[i_addr];
  end
  assign o_rdata = r_q;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: request/ready data memory with post-reset clear sweep, range check and registered read.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                busy,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);
  localparam int CW = cnt_w(DEPTH);
  state_t            r_state;
  logic [CW-1:0]     r_clr_idx;
  logic              r_rvalid, r_err, r_zero;
  logic              w_acc, w_inr, w_clr, w_mwe, w_mre;
  logic [CW-1:0]     w_maddr;
  logic [DATA_W/8-1:0] w_mbe;
  logic [DATA_W-1:0] w_mwd, w_q;
  assign w_acc   = req && (r_state == IDLE);
  assign w_inr   = addr < ADDR_W'(DEPTH);
  // rst_n gate keeps the sweep from writing while reset is held
  assign w_clr   = rst_n && (r_state == CLEAR);
  assign w_mwe   = w_clr || (w_acc && we && w_inr);
  assign w_mre   = w_acc && !we && w_inr;
  assign w_maddr = w_clr ? r_clr_idx : addr[CW-1:0];
  assign w_mbe   = w_clr ? '1 : be;
  assign w_mwd   = w_clr ? '0 : wdata;
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(CW)) u_array (
    .clk(clk), .i_we(w_mwe), .i_re(w_mre), .i_addr(w_maddr),
    .i_be(w_mbe), .i_wdata(w_mwd), .o_rdata(w_q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      r_clr_idx <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_zero    <= 1'b1;
    end else begin
      if (r_state == CLEAR) begin
        r_clr_idx <= (r_clr_idx == CW'(DEPTH - 1)) ? '0 : r_clr_idx + 1'b1;
        if (r_clr_idx == CW'(DEPTH - 1)) r_state <= IDLE;
      end
      r_rvalid <= w_acc && !we;
      r_err    <= w_acc && !w_inr;
      if (w_acc && !we) r_zero <= !w_inr;
    end
  end
  // r_zero masks the array output until a real read lands, and for out-of-range reads
  assign rdata  = r_zero ? '0 : w_q;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == CLEAR);
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a behavioural memory model.
module tb_dmem_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  be = 0;
  logic        ready, busy, rvalid, err;
  logic [31:0] rdata;
  logic        ready1, busy1, rvalid1, err1;
  logic [31:0] rdata1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .INIT_CLEAR(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err));

  dmem_ctrl #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .INIT_CLEAR(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .err(err1));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  logic [31:0] m [128];
  int          clr_left = 128;
  logic        e_rvalid = 0, e_err = 0, e1_rvalid = 0, e1_err = 0, e1_zero = 1;
  logic [31:0] e_rdata = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left = 128; e_rvalid = 0; e_err = 0; e_rdata = 0;
      e1_rvalid = 0; e1_err = 0; e1_zero = 1;
    end else begin
      e_rvalid = 0; e_err = 0;
      e1_rvalid = req && !we;
      e1_err = req && addr >= 128;
      if (req && !we) e1_zero = addr >= 128;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) for (int i = 0; i < 128; i++) m[i] = 0;
      end else if (req) begin
        if (we) begin
          if (addr < 128) begin
            for (int b = 0; b < 4; b++) if (be[b]) m[addr][8*b +: 8] = wdata[8*b +: 8];
          end else e_err = 1;
        end else begin
          e_rvalid = 1;
          e_rdata = (addr < 128) ? m[addr] : 0;
          e_err = addr >= 128;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, clr_left != 0});
    chk("ready", {31'b0, ready}, {31'b0, clr_left == 0});
    chk("rvalid", {31'b0, rvalid}, {31'b0, e_rvalid});
    chk("err", {31'b0, err}, {31'b0, e_err});
    chk("rdata", rdata, e_rdata);
    chk("ready_noclr", {31'b0, ready1, busy1}, 32'd2);
    chk("rvalid_noclr", {31'b0, rvalid1, err1}, {30'b0, e1_rvalid, e1_err});
    if (e1_zero) chk("rdata_noclr", rdata1, 32'd0);
  end

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  int n;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    wait_clear(n);
    chk("clear_len", n, 128);
    op(0, 127, 0, 0);
    chk("rd127_valid", {31'b0, rvalid}, 32'd1);
    chk("rd127_data", rdata, 32'd0);
    op(1, 5, 32'hDEADBEEF, 4'b1111);
    op(1, 5, 32'h000000AA, 4'b0001);
    op(0, 5, 0, 0);
    chk("rd5_merge", rdata, 32'hDEADBEAA);
    op(1, 6, 32'h12345678, 4'b0000);
    op(0, 6, 0, 0);
    chk("be0_noop", rdata, 32'd0);
    for (int i = 0; i < 4; i++) op(1, i, 32'hA0000000 + i, 4'hF);
    for (int i = 0; i < 4; i++) begin
      op(0, i, 0, 0);
      chk("b2b_rvalid", {31'b0, rvalid}, 32'd1);
      chk("b2b_rdata", rdata, 32'hA0000000 + i);
    end
    op(0, 128, 0, 0);
    chk("oor_rd", {30'b0, rvalid, err}, 32'd3);
    chk("oor_rdata", rdata, 32'd0);
    op(1, 200, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr", {30'b0, rvalid, err}, 32'd1);
    op(1, 32'h80000005, 32'h55555555, 4'hF);
    chk("oor_hi", {31'b0, err}, 32'd1);
    for (int i = 0; i < 128; i++) op(0, i, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      req = ($urandom_range(0, 3) != 0); we = $urandom_range(0, 1) == 1;
      addr = $urandom_range(0, 140); wdata = $urandom; be = 4'($urandom);
      @(posedge clk); #1;
    end
    req = 0;
    op(0, 5, 0, 0);
    chk("rd5_after_rand", rdata, m[5]);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    req = 1; we = 0; addr = 127;
    repeat (60) @(posedge clk);
    #1 rst_n = 0;
    chk("async_rst", {29'b0, ready, busy, rvalid}, 32'd2);
    @(posedge clk); #1 rst_n = 1;
    wait_clear(n);
    chk("restart_len", n, 128);
    @(posedge clk); #1;
    chk("first_idle_acc", {31'b0, rvalid}, 32'd1);
    chk("first_idle_data", rdata, 32'd0);
    req = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
